// File: rtl/mem_stage_pipe.sv
// Memory stage pipeline register: accepts ALU results and loads,
// waits for the memory response and extracts/extends load data.
module mem_stage_pipe #(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_load,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [1:0]          in_part,
    input  logic [4:0]          in_dest,
    input  logic [DATA_W-1:0]   in_value,
    input  logic [31:0]         in_pc,
    input  logic [31:0]         in_inst,
    input  logic                rsp_valid,
    input  logic [DATA_W-1:0]   rsp_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          out_dest,
    output logic [DATA_W-1:0]   out_value,
    output logic [DATA_W/8-1:0] out_wen,
    output logic [31:0]         out_pc,
    output logic [31:0]         out_inst,
    output logic                fwd_pending,
    output logic                rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              err_q, err_d;
    logic [4:0]        dest_q, dest_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [NB-1:0]     wen_q, wen_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        part_q, part_d;
    logic [2:0]        ofs_q, ofs_d;

    logic              accept;
    logic [DATA_W-1:0] load_value;
    logic [NB-1:0]     load_wen;

    logic [OFS_W-1:0]  lane;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign;
    logic [5:0]        wsh;
    logic [31:0]       word;
    logic [1:0]        j;
    logic [31:0]       pv;
    logic [3:0]        pw;

    assign in_ready    = (state_q == S_EMPTY) | ((state_q == S_FULL) & out_ready);
    assign accept      = in_valid & in_ready & ~flush;
    assign out_valid   = (state_q == S_FULL);
    assign fwd_pending = (state_q == S_WAIT);
    assign rsp_err     = err_q;
    assign out_dest    = dest_q;
    assign out_value   = value_q;
    assign out_wen     = wen_q;
    assign out_pc      = pc_q;
    assign out_inst    = inst_q;

    // Load data extraction: aligned lane select plus extension, or lwl/lwr merge.
    always_comb begin
        lane    = ofs_q[OFS_W-1:0] & ~((OFS_W'(1) << size_q) - OFS_W'(1));
        shifted = rsp_data >> {lane, 3'b000};
        mask    = '1;
        sign    = shifted[DATA_W-1];
        case (size_q)
            2'd0: begin
                mask = DATA_W'(8'hFF);
                sign = shifted[7];
            end
            2'd1: begin
                mask = DATA_W'(16'hFFFF);
                sign = shifted[15];
            end
            2'd2: begin
                mask = DATA_W'(32'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                mask = '1;
                sign = shifted[DATA_W-1];
            end
        endcase
        wsh  = (DATA_W == 64 && ofs_q[2]) ? 6'd32 : 6'd0;
        word = 32'(rsp_data >> wsh);
        j    = ofs_q[1:0];
        pv   = '0;
        pw   = '0;
        if (part_q == 2'd1) begin
            pv = word << {2'd3 - j, 3'b000};
            pw = 4'hF << (2'd3 - j);
        end else if (part_q == 2'd2) begin
            pv = word >> {j, 3'b000};
            pw = 4'hF >> j;
        end
        if (part_q == 2'd1 || part_q == 2'd2) begin
            load_value = DATA_W'(pv);
            load_wen   = NB'(pw);
        end else begin
            load_value = (shifted & mask) | ((~uns_q & sign) ? ~mask : '0);
            load_wen   = '1;
        end
    end

    // Next-state logic: handshake FSM, field capture and sticky error.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        dest_d  = dest_q;
        value_d = value_q;
        wen_d   = wen_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        size_d  = size_q;
        uns_d   = uns_q;
        part_d  = part_q;
        ofs_d   = ofs_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) state_d = in_load ? S_WAIT : S_FULL;
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = rsp_valid ? S_EMPTY : S_DRAIN;
                end else if (rsp_valid) begin
                    state_d = S_FULL;
                    value_d = load_value;
                    wen_d   = load_wen;
                end
            end
            S_FULL: begin
                if (flush) state_d = S_EMPTY;
                else if (accept) state_d = in_load ? S_WAIT : S_FULL;
                else if (out_ready) state_d = S_EMPTY;
            end
            default: begin
                if (rsp_valid) state_d = S_EMPTY;
            end
        endcase
        if (accept) begin
            dest_d  = in_dest;
            value_d = in_value;
            wen_d   = '1;
            pc_d    = in_pc;
            inst_d  = in_inst;
            size_d  = in_size;
            uns_d   = in_unsigned;
            part_d  = in_part;
            ofs_d   = in_value[2:0];
        end
        if (rsp_valid && (state_q == S_EMPTY || state_q == S_FULL)) err_d = 1'b1;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
            err_q   <= 1'b0;
            dest_q  <= '0;
            value_q <= '0;
            wen_q   <= '0;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            part_q  <= '0;
            ofs_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            dest_q  <= dest_d;
            value_q <= value_d;
            wen_q   <= wen_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            part_q  <= part_d;
            ofs_q   <= ofs_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: 32- and 64-bit instances share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_mem_stage_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_load = 1'b0;
    logic [1:0]  in_size = '0;
    logic        in_unsigned = 1'b0;
    logic [1:0]  in_part = '0;
    logic [4:0]  in_dest = '0;
    logic [63:0] in_value = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        rsp_valid = 1'b0;
    logic [63:0] rsp_data = '0;
    logic        out_ready = 1'b1;

    logic        rdy32, ov32, fwd32, err32;
    logic [4:0]  dst32;
    logic [31:0] val32;
    logic [3:0]  wen32;
    logic [31:0] pc32, inst32;
    logic        rdy64, ov64, fwd64, err64;
    logic [4:0]  dst64;
    logic [63:0] val64;
    logic [7:0]  wen64;
    logic [31:0] pc64, inst64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.DATA_W(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_load(in_load),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_part(in_part),
        .in_dest(in_dest), .in_value(in_value[31:0]), .in_pc(in_pc),
        .in_inst(in_inst), .rsp_valid(rsp_valid), .rsp_data(rsp_data[31:0]),
        .out_valid(ov32), .out_ready(out_ready), .out_dest(dst32),
        .out_value(val32), .out_wen(wen32), .out_pc(pc32),
        .out_inst(inst32), .fwd_pending(fwd32), .rsp_err(err32)
    );

    mem_stage_pipe #(.DATA_W(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_load(in_load),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_part(in_part),
        .in_dest(in_dest), .in_value(in_value), .in_pc(in_pc),
        .in_inst(in_inst), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_valid(ov64), .out_ready(out_ready), .out_dest(dst64),
        .out_value(val64), .out_wen(wen64), .out_pc(pc64),
        .out_inst(inst64), .fwd_pending(fwd64), .rsp_err(err64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference extraction from the stated rules; returns {wen, value}.
    function automatic logic [71:0] mx(input int dw, input logic [63:0] addr,
                                       input logic [63:0] data, input logic [1:0] size,
                                       input logic uns, input logic [1:0] part);
        logic [63:0] d, raw, msk;
        logic [31:0] word, t;
        logic [7:0]  w;
        int nb, n, k, jj;
        nb = dw / 8;
        d  = (dw == 32) ? {32'h0, data[31:0]} : data;
        w  = '0;
        if (part == 2'd1 || part == 2'd2) begin
            word = (dw == 64 && addr[2]) ? data[63:32] : data[31:0];
            jj = int'(addr[1:0]);
            if (part == 2'd1) t = word << (24 - 8 * jj);
            else t = word >> (8 * jj);
            for (int b = 0; b < 4; b++)
                w[b] = (part == 2'd1) ? (b >= 3 - jj) : (b < 4 - jj);
            return {w, 32'h0, t};
        end
        n = 1 << size;
        if (n > nb) n = nb;
        k = (int'(addr[2:0]) % nb) / n * n;
        raw = d >> (8 * k);
        if (n < 8) begin
            msk = (64'd1 << (8 * n)) - 64'd1;
            raw = raw & msk;
            if (!uns && raw[8 * n - 1]) raw = raw | ~msk;
        end
        if (dw == 32) raw[63:32] = '0;
        w = (dw == 32) ? 8'h0F : 8'hFF;
        return {w, raw};
    endfunction

    // Model: stage either holds nothing, a result, a load waiting, or a flushed load.
    logic        m_have = 1'b0, m_wait = 1'b0, m_drain = 1'b0, m_err = 1'b0;
    logic [4:0]  m_dest;
    logic [31:0] m_pc, m_inst;
    logic [63:0] m_v32, m_v64;
    logic [7:0]  m_w32, m_w64;
    logic        m_skip32;
    logic [63:0] p_addr;
    logic [1:0]  p_size, p_part;
    logic        p_uns;

    function automatic logic exp_rdy();
        return !m_wait && !m_drain && (!m_have || out_ready);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_have  <= 1'b0;
            m_wait  <= 1'b0;
            m_drain <= 1'b0;
            m_err   <= 1'b0;
        end else if (m_drain) begin
            if (rsp_valid) m_drain <= 1'b0;
        end else if (m_wait) begin
            if (flush) begin
                m_wait  <= 1'b0;
                m_drain <= !rsp_valid;
            end else if (rsp_valid) begin
                m_wait <= 1'b0;
                m_have <= 1'b1;
                {m_w32, m_v32} <= mx(32, p_addr, rsp_data, p_size, p_uns, p_part);
                {m_w64, m_v64} <= mx(64, p_addr, rsp_data, p_size, p_uns, p_part);
            end
        end else begin
            if (rsp_valid) m_err <= 1'b1;
            if (flush) begin
                m_have <= 1'b0;
            end else if (in_valid && exp_rdy()) begin
                m_dest   <= in_dest;
                m_pc     <= in_pc;
                m_inst   <= in_inst;
                m_skip32 <= in_load && in_part != 2'd1 && in_part != 2'd2 && in_size == 2'd3;
                if (in_load) begin
                    m_have <= 1'b0;
                    m_wait <= 1'b1;
                    p_addr <= in_value;
                    p_size <= in_size;
                    p_uns  <= in_unsigned;
                    p_part <= in_part;
                end else begin
                    m_have <= 1'b1;
                    m_v32  <= {32'h0, in_value[31:0]};
                    m_w32  <= 8'h0F;
                    m_v64  <= in_value;
                    m_w64  <= 8'hFF;
                end
            end else if (m_have && out_ready) begin
                m_have <= 1'b0;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always begin
        @(negedge clk);
        #1;
        chk("in_ready32", rdy32, exp_rdy());
        chk("in_ready64", rdy64, exp_rdy());
        chk("out_valid32", ov32, m_have);
        chk("out_valid64", ov64, m_have);
        chk("fwd32", fwd32, m_wait);
        chk("fwd64", fwd64, m_wait);
        chk("err32", err32, m_err);
        chk("err64", err64, m_err);
        if (m_have) begin
            chk("dest32", dst32, m_dest);
            chk("dest64", dst64, m_dest);
            chk("pc32", pc32, m_pc);
            chk("inst64", inst64, m_inst);
            chk("value64", val64, m_v64);
            chk("wen64", wen64, m_w64);
            if (!m_skip32) begin
                chk("value32", val32, m_v32[31:0]);
                chk("wen32", wen32, m_w32[3:0]);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic load_txn(input logic [1:0] sz, input logic un, input logic [1:0] pt,
                            input logic [63:0] addr, input logic [63:0] data, input int dly);
        in_valid = 1'b1;
        in_load = 1'b1;
        in_size = sz;
        in_unsigned = un;
        in_part = pt;
        in_value = addr;
        in_dest = 5'd9;
        in_pc = 32'h1000_0040;
        in_inst = 32'h8c00_0000;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < dly; i++) begin
            chk("fwd_wait", fwd32, 1'b1);
            if (i == dly - 1) begin
                rsp_valid = 1'b1;
                rsp_data = data;
            end
            cyc();
        end
        rsp_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        chk("rst_pc32", pc32, 32'hbfc00000);
        chk("rst_pc64", pc64, 32'hbfc00000);
        chk("rst_value", val32, 32'h0);
        chk("rst_wen", wen32, 4'h0);
        chk("rst_inst", inst32, 32'h0);
        chk("rst_valid", ov32, 1'b0);
        chk("rst_rdy", rdy32, 1'b1);

        // plain ALU result
        in_valid = 1'b1;
        in_load = 1'b0;
        in_value = 64'h1234;
        in_dest = 5'd5;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("alu_valid", ov32, 1'b1);
        chk("alu_value", val32, 32'h1234);
        chk("alu_wen", wen32, 4'hF);
        cyc();
        chk("alu_gone", ov32, 1'b0);

        // lb / lbu with a three-cycle response
        load_txn(2'd0, 1'b0, 2'd0, 64'h1001, 64'h8000, 3);
        chk("lb_value", val32, 32'hFFFF_FF80);
        chk("lb_fwd", fwd32, 1'b0);
        cyc();
        load_txn(2'd0, 1'b1, 2'd0, 64'h1001, 64'h8000, 3);
        chk("lbu_value", val32, 32'h0000_0080);
        cyc();

        // partial left / right
        load_txn(2'd2, 1'b0, 2'd1, 64'h2001, 64'hAABB_CCDD, 1);
        chk("lwl_value", val32, 32'hCCDD_0000);
        chk("lwl_wen", wen32, 4'b1100);
        chk("lwl_value64", val64, 64'h0000_0000_CCDD_0000);
        chk("lwl_wen64", wen64, 8'h0C);
        cyc();
        load_txn(2'd2, 1'b0, 2'd2, 64'h2002, 64'hAABB_CCDD, 1);
        chk("lwr_value", val32, 32'h0000_AABB);
        chk("lwr_wen", wen32, 4'b0011);
        cyc();

        // 64-bit dword and upper-word lw
        load_txn(2'd3, 1'b0, 2'd0, 64'h3000, 64'h0123_4567_89AB_CDEF, 1);
        chk("ld_value64", val64, 64'h0123_4567_89AB_CDEF);
        chk("ld_wen64", wen64, 8'hFF);
        cyc();
        load_txn(2'd2, 1'b0, 2'd0, 64'h3004, 64'h8000_0001_1234_5678, 2);
        chk("lw_hi64", val64, 64'hFFFF_FFFF_8000_0001);
        chk("lw_lo32", val32, 32'h1234_5678);
        cyc();

        // flush while waiting, response two cycles later
        in_valid = 1'b1;
        in_load = 1'b1;
        in_part = 2'd0;
        in_size = 2'd2;
        in_value = 64'h40;
        cyc();
        in_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("drain_rdy", rdy32, 1'b0);
        chk("drain_fwd", fwd32, 1'b0);
        cyc();
        rsp_valid = 1'b1;
        cyc();
        rsp_valid = 1'b0;
        chk("drain_done", rdy32, 1'b1);
        chk("drain_nov", ov32, 1'b0);
        chk("drain_err", err32, 1'b0);
        rsp_valid = 1'b1;
        cyc();
        rsp_valid = 1'b0;
        chk("stray_err", err32, 1'b1);
        reset = 1'b1;
        #1;
        chk("err_clr", err32, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #2;

        // flush and response together
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        flush = 1'b1;
        rsp_valid = 1'b1;
        cyc();
        flush = 1'b0;
        rsp_valid = 1'b0;
        chk("fr_empty", rdy32, 1'b1);
        chk("fr_err", err32, 1'b0);

        // reset in the middle of a wait
        in_valid = 1'b1;
        in_pc = 32'h1234_5678;
        cyc();
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("mid_fwd", fwd32, 1'b0);
        chk("mid_pc", pc32, 32'hbfc00000);
        @(negedge clk);
        reset = 1'b0;
        #2;
        rsp_valid = 1'b1;
        cyc();
        rsp_valid = 1'b0;
        chk("mid_err", err32, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();

        // backpressure, then back-to-back
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_load = 1'b0;
        in_value = 64'hA1;
        cyc();
        in_value = 64'hB2;
        for (int i = 0; i < 4; i++) begin
            chk("bp_rdy", rdy32, 1'b0);
            chk("bp_value", val32, 32'hA1);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", rdy32, 1'b1);
        cyc();
        in_valid = 1'b0;
        chk("b2b_valid", ov32, 1'b1);
        chk("b2b_value", val32, 32'hB2);
        cyc();
        chk("b2b_empty", ov32, 1'b0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom % 2);
            in_load = 1'($urandom % 2);
            in_size = 2'($urandom % 4);
            in_unsigned = 1'($urandom % 2);
            in_part = ($urandom % 4 == 0) ? 2'(1 + $urandom % 2) : 2'd0;
            in_dest = 5'($urandom);
            in_value = {$urandom, $urandom};
            in_pc = $urandom;
            in_inst = $urandom;
            out_ready = ($urandom % 3 != 0);
            flush = ($urandom % 12 == 0);
            rsp_valid = (m_wait || m_drain) && ($urandom % 3 == 0);
            rsp_data = {$urandom, $urandom};
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
